// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register carrying a control field and a
// payload field, with valid/ready handshakes on both sides.
//
// SKID=1 holds up to two entries (head M plus skid S). in_ready depends
// only on the state register and stall/flush, so there is no
// combinational path from out_ready to in_ready.
// SKID=0 holds a single entry. in_ready looks through to out_ready, which
// lets the stage refill in the same cycle it drains.
//
// A control field of zero marks a bubble. out_ctrl is forced to zero
// whenever nothing is presented downstream.
//
// state | meaning
// ------+----------------------------------------------------
// EMPTY | no entry held, nothing presented downstream
// ONE   | head entry M valid and presented downstream
// TWO   | M presented, skid entry S queued behind it (SKID=1)

module pipe_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 8,
    parameter int SKID     = 1,
    parameter int CNT_W    = 16,
    parameter int CLR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              in_fire;
    logic              out_fire;
    logic              bubble_inc;

    // The reset term keeps in_ready low while reset is held. The stage
    // still accepts on the very first edge after reset is released.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = reset & (state != TWO) & ~stall & ~flush;
        end else begin : g_single
            assign in_ready = reset & ~stall & ~flush &
                              ((state == EMPTY) | out_ready);
        end
    endgenerate

    assign out_valid  = (state != EMPTY) & ~stall;
    assign out_ctrl   = out_valid ? m_ctrl : '0;
    assign out_data   = m_data;

    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign bubble_inc = out_ready & ~out_valid & ~stall & ~flush;

    // Entry state machine. Flush wins over stall and every transfer.
    // A stall holds everything in place, because both handshakes are
    // already masked. Payload left in a vacated entry is not cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            m_ctrl <= '0;
            m_data <= '0;
            s_ctrl <= '0;
            s_data <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            m_ctrl <= '0;
            s_ctrl <= '0;
            if (CLR_DATA != 0) begin
                m_data <= '0;
                s_data <= '0;
            end
        end else if (!stall) begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_ctrl <= in_ctrl;
                        m_data <= in_data;
                    end else if (in_fire) begin
                        // Only reachable with SKID=1: in the single-entry
                        // build, in_ready in ONE implies out_fire.
                        s_ctrl <= in_ctrl;
                        s_data <= in_data;
                        state  <= TWO;
                    end else if (out_fire) begin
                        state  <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        m_ctrl <= s_ctrl;
                        m_data <= s_data;
                        state  <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Saturating count of cycles in which downstream was ready but
    // received nothing. Only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (bubble_inc && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    // Occupancy decode from the state register.
    always_comb begin
        occupancy = 2'd0;
        case (state)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule
